mpu_axi_rr_arbiter: RTL
=======================

Name: mpu_axi_rr_arbiter

Overview:
- Two-master to one-slave AXI4 arbiter that shares a single downstream AXI port between two requesters.
- Typical requesters are a DMA engine and a compute-unit port; the downstream port is normally an axi2axi connector slave interface.
- Write (AW/W/B) and read (AR/R) paths are arbitrated independently, round-robin, with one outstanding transaction per path.
- Counts write beats against AWLEN and flags WLAST protocol errors.

Parameters:
ADDR_W, 32, address width on all ports
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
ACLK  in  1  clock, all logic rising-edge
ARESET  in  1  synchronous, active-high reset
Sn_AXI_AWADDR/AWLEN/AWSIZE/AWBURST  in  ADDR_W/8/3/2  write address, master n (n=0,1)
Sn_AXI_AWVALID  in  1 ; Sn_AXI_AWREADY  out  1  write address handshake
Sn_AXI_WDATA/WSTRB/WLAST/WVALID  in  DATA_W/DATA_W/8/1/1 ; Sn_AXI_WREADY  out  1  write data
Sn_AXI_BRESP  out  2 ; Sn_AXI_BVALID  out  1 ; Sn_AXI_BREADY  in  1  write response
Sn_AXI_ARADDR/ARLEN/ARSIZE/ARBURST  in  ADDR_W/8/3/2 ; Sn_AXI_ARVALID  in  1 ; Sn_AXI_ARREADY  out  1  read address
Sn_AXI_RDATA  out  DATA_W ; Sn_AXI_RRESP  out  2 ; Sn_AXI_RLAST/RVALID  out  1 ; Sn_AXI_RREADY  in  1  read data
M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  1/ADDR_W/8/3/2/1 ; M_AXI_AWREADY  in  1  downstream write address
M_AXI_WDATA/WSTRB/WLAST/WVALID  out  DATA_W/DATA_W/8/1/1 ; M_AXI_WREADY  in  1  downstream write data
M_AXI_BID  in  1 ; M_AXI_BRESP  in  2 ; M_AXI_BVALID  in  1 ; M_AXI_BREADY  out  1  downstream response
M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  1/ADDR_W/8/3/2/1 ; M_AXI_ARREADY  in  1  downstream read address
M_AXI_RID  in  1 ; M_AXI_RDATA  in  DATA_W ; M_AXI_RRESP  in  2 ; M_AXI_RLAST/RVALID  in  1 ; M_AXI_RREADY  out  1  downstream read data
WLAST_ERR  out  1  sticky: master WLAST disagreed with beat count
WGNT/RGNT  out  1  current write/read grant index (debug)

Behaviour:
Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
- W_IDLE: if any Sn_AWVALID, register the grant and go to W_ADDR.
  - Single requester wins.
  - Both requesting: the master != w_last wins.
- W_ADDR: M_AW* = granted Sn_AW*; M_AWID = grant index; Sg_AWREADY = M_AWREADY.
  - On handshake: latch AWLEN into len_q, clear beat counter, go to W_DATA.
- W_DATA: M_W* = granted W*; M_WLAST = (beat == len_q), not the master's WLAST.
  - Each W handshake increments beat.
  - If the master's WLAST != (beat == len_q) on a handshake, set WLAST_ERR.
  - Handshake with beat == len_q goes to W_RESP.
- W_RESP: M_BREADY = Sg_BREADY; Sg_BVALID/BRESP = M_BVALID/BRESP.
  - On handshake: w_last <= grant, go to W_IDLE.
  - M_BID is ignored; routing uses the registered grant.
Read FSM states: R_IDLE, R_ADDR, R_DATA.
- Grant rule is the same as the write FSM, using r_last; M_ARID = grant index.
- R_DATA routes R to the granted master; handshake with M_RLAST=1 sets r_last <= grant and returns to R_IDLE.
Non-granted master, and any master in IDLE states:
- all READY/VALID outputs 0.
- data outputs 0.
All M valid/ready outputs are 0 in states that do not drive them.
Latency:
- M_AWVALID/M_ARVALID rise the cycle after Sn_*VALID is first sampled in IDLE.
- After that, the path is combinational pass-through; no data buffering.
Reset (ARESET=1 at an edge):
- states to IDLE; w_last = r_last = 1, so master 0 wins the first tie.
- beat = 0, len_q = 0, WLAST_ERR = 0, WGNT = RGNT = 0.
- every VALID/READY output 0.
- Reset mid-burst aborts with no completion to either side.
Boundary conditions:
- AWLEN=0: single beat, M_WLAST=1 on the first beat.
- AWLEN=255: beat counter is 8 bits and must not wrap before the final beat.
- Write and read paths may both be active at once, granted to the same or different masters.
- A master dropping AWVALID before the handshake (protocol violation) leaves the FSM in W_ADDR; no recovery is required.
- WLAST_ERR clears only on reset.

Test Plan:
- Reset, then S0 writes AWADDR=0x100, AWLEN=3, 4 beats, M_AWREADY=M_WREADY=1, BRESP=OKAY -> M_AWVALID high 1 cycle after S0_AWVALID; 4 M_W beats; M_WLAST on beat 4 only; S0_BVALID=1 with BRESP=0; S1 ready signals stay 0.
- S0 and S1 assert AWVALID in the same cycle, each AWLEN=0, repeated 3 times -> M_AWID sequence 0,1,0; WGNT matches each time.
- S1 reads ARLEN=7 while S0 writes AWLEN=7 concurrently -> both complete; RGNT=1, WGNT=0; 8 R beats reach S1 only; 8 W beats from S0.
- S0 asserts WLAST on beat 2 of AWLEN=3 -> WLAST_ERR=1 from the next cycle; M_WLAST still only on beat 4; transaction completes.
- M_AWREADY held 0 for 5 cycles, then 1 -> S0_AWREADY low for 5 cycles; AW signals stable; handshake on cycle 6.
- ARESET pulsed mid-way through an 8-beat read -> next cycle all VALID/READY outputs 0; a subsequent simultaneous request grants master 0.

Source files
------------

// File: rtl/mpu_axi_rr_arbiter_if.sv
// AXI4 bus bundle shared by the two upstream requesters and the downstream port.
// IDs are one bit wide: the arbiter tags downstream transactions with the grant index.
interface mpu_axi_rr_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic       bid;
  logic [1:0] bresp;
  logic       bvalid;
  logic       bready;

  logic              arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic              rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/mpu_axi_rr_arbiter.sv
// Two-master to one-slave AXI4 arbiter; write and read paths are arbitrated
// independently, round-robin, one outstanding transaction per path.
module mpu_axi_rr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  mpu_axi_rr_arbiter_if.slave   s0_axi,
  mpu_axi_rr_arbiter_if.slave   s1_axi,
  mpu_axi_rr_arbiter_if.master  m_axi,
  output logic                  WLAST_ERR,
  output logic                  WGNT,
  output logic                  RGNT
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  w_state_e   w_state_q, w_state_d;
  logic       w_gnt_q, w_gnt_d;
  logic       w_last_q, w_last_d;
  logic [7:0] len_q, len_d;
  logic [7:0] beat_q, beat_d;
  logic       wlast_err_q, wlast_err_d;
  r_state_e   r_state_q, r_state_d;
  logic       r_gnt_q, r_gnt_d;
  logic       r_last_q, r_last_d;
  logic       beat_is_last;

  logic [ADDR_W-1:0]   g_awaddr, g_araddr;
  logic [7:0]          g_awlen, g_arlen;
  logic [2:0]          g_awsize, g_arsize;
  logic [1:0]          g_awburst, g_arburst;
  logic                g_awvalid, g_arvalid;
  logic [DATA_W-1:0]   g_wdata;
  logic [DATA_W/8-1:0] g_wstrb;
  logic                g_wlast, g_wvalid, g_bready, g_rready;

  // Upstream signals of whichever master currently holds each path's grant
  assign g_awaddr  = w_gnt_q ? s1_axi.awaddr  : s0_axi.awaddr;
  assign g_awlen   = w_gnt_q ? s1_axi.awlen   : s0_axi.awlen;
  assign g_awsize  = w_gnt_q ? s1_axi.awsize  : s0_axi.awsize;
  assign g_awburst = w_gnt_q ? s1_axi.awburst : s0_axi.awburst;
  assign g_awvalid = w_gnt_q ? s1_axi.awvalid : s0_axi.awvalid;
  assign g_wdata   = w_gnt_q ? s1_axi.wdata   : s0_axi.wdata;
  assign g_wstrb   = w_gnt_q ? s1_axi.wstrb   : s0_axi.wstrb;
  assign g_wlast   = w_gnt_q ? s1_axi.wlast   : s0_axi.wlast;
  assign g_wvalid  = w_gnt_q ? s1_axi.wvalid  : s0_axi.wvalid;
  assign g_bready  = w_gnt_q ? s1_axi.bready  : s0_axi.bready;
  assign g_araddr  = r_gnt_q ? s1_axi.araddr  : s0_axi.araddr;
  assign g_arlen   = r_gnt_q ? s1_axi.arlen   : s0_axi.arlen;
  assign g_arsize  = r_gnt_q ? s1_axi.arsize  : s0_axi.arsize;
  assign g_arburst = r_gnt_q ? s1_axi.arburst : s0_axi.arburst;
  assign g_arvalid = r_gnt_q ? s1_axi.arvalid : s0_axi.arvalid;
  assign g_rready  = r_gnt_q ? s1_axi.rready  : s0_axi.rready;

  assign WLAST_ERR = wlast_err_q;
  assign WGNT      = w_gnt_q;
  assign RGNT      = r_gnt_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q   <= W_IDLE;
      w_gnt_q     <= 1'b0;
      w_last_q    <= 1'b1;
      len_q       <= '0;
      beat_q      <= '0;
      wlast_err_q <= 1'b0;
      r_state_q   <= R_IDLE;
      r_gnt_q     <= 1'b0;
      r_last_q    <= 1'b1;
    end else begin
      w_state_q   <= w_state_d;
      w_gnt_q     <= w_gnt_d;
      w_last_q    <= w_last_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      wlast_err_q <= wlast_err_d;
      r_state_q   <= r_state_d;
      r_gnt_q     <= r_gnt_d;
      r_last_q    <= r_last_d;
    end
  end

  // Downstream WLAST comes from our own beat count, never from the master
  always_comb begin
    w_state_d      = w_state_q;
    w_gnt_d        = w_gnt_q;
    w_last_d       = w_last_q;
    len_d          = len_q;
    beat_d         = beat_q;
    wlast_err_d    = wlast_err_q;
    beat_is_last   = (beat_q == len_q);
    m_axi.awid     = 1'b0;
    m_axi.awaddr   = '0;
    m_axi.awlen    = '0;
    m_axi.awsize   = '0;
    m_axi.awburst  = '0;
    m_axi.awvalid  = 1'b0;
    m_axi.wdata    = '0;
    m_axi.wstrb    = '0;
    m_axi.wlast    = 1'b0;
    m_axi.wvalid   = 1'b0;
    m_axi.bready   = 1'b0;
    s0_axi.awready = 1'b0;
    s0_axi.wready  = 1'b0;
    s0_axi.bvalid  = 1'b0;
    s0_axi.bresp   = '0;
    s0_axi.bid     = 1'b0;
    s1_axi.awready = 1'b0;
    s1_axi.wready  = 1'b0;
    s1_axi.bvalid  = 1'b0;
    s1_axi.bresp   = '0;
    s1_axi.bid     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s0_axi.awvalid || s1_axi.awvalid) begin
          w_gnt_d   = (s0_axi.awvalid && s1_axi.awvalid) ? ~w_last_q : s1_axi.awvalid;
          w_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        m_axi.awid    = w_gnt_q;
        m_axi.awaddr  = g_awaddr;
        m_axi.awlen   = g_awlen;
        m_axi.awsize  = g_awsize;
        m_axi.awburst = g_awburst;
        m_axi.awvalid = g_awvalid;
        if (w_gnt_q) s1_axi.awready = m_axi.awready;
        else         s0_axi.awready = m_axi.awready;
        if (g_awvalid && m_axi.awready) begin
          len_d     = g_awlen;
          beat_d    = '0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        m_axi.wdata  = g_wdata;
        m_axi.wstrb  = g_wstrb;
        m_axi.wlast  = beat_is_last;
        m_axi.wvalid = g_wvalid;
        if (w_gnt_q) s1_axi.wready = m_axi.wready;
        else         s0_axi.wready = m_axi.wready;
        if (g_wvalid && m_axi.wready) begin
          beat_d = beat_q + 8'd1;
          if (g_wlast != beat_is_last) wlast_err_d = 1'b1;
          if (beat_is_last) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        m_axi.bready = g_bready;
        if (w_gnt_q) begin
          s1_axi.bvalid = m_axi.bvalid;
          s1_axi.bresp  = m_axi.bresp;
        end else begin
          s0_axi.bvalid = m_axi.bvalid;
          s0_axi.bresp  = m_axi.bresp;
        end
        if (m_axi.bvalid && g_bready) begin
          w_last_d  = w_gnt_q;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read path: same grant rule, burst ends on the downstream RLAST
  always_comb begin
    r_state_d      = r_state_q;
    r_gnt_d        = r_gnt_q;
    r_last_d       = r_last_q;
    m_axi.arid     = 1'b0;
    m_axi.araddr   = '0;
    m_axi.arlen    = '0;
    m_axi.arsize   = '0;
    m_axi.arburst  = '0;
    m_axi.arvalid  = 1'b0;
    m_axi.rready   = 1'b0;
    s0_axi.arready = 1'b0;
    s0_axi.rvalid  = 1'b0;
    s0_axi.rdata   = '0;
    s0_axi.rresp   = '0;
    s0_axi.rlast   = 1'b0;
    s0_axi.rid     = 1'b0;
    s1_axi.arready = 1'b0;
    s1_axi.rvalid  = 1'b0;
    s1_axi.rdata   = '0;
    s1_axi.rresp   = '0;
    s1_axi.rlast   = 1'b0;
    s1_axi.rid     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (s0_axi.arvalid || s1_axi.arvalid) begin
          r_gnt_d   = (s0_axi.arvalid && s1_axi.arvalid) ? ~r_last_q : s1_axi.arvalid;
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_axi.arid    = r_gnt_q;
        m_axi.araddr  = g_araddr;
        m_axi.arlen   = g_arlen;
        m_axi.arsize  = g_arsize;
        m_axi.arburst = g_arburst;
        m_axi.arvalid = g_arvalid;
        if (r_gnt_q) s1_axi.arready = m_axi.arready;
        else         s0_axi.arready = m_axi.arready;
        if (g_arvalid && m_axi.arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        m_axi.rready = g_rready;
        if (r_gnt_q) begin
          s1_axi.rvalid = m_axi.rvalid;
          s1_axi.rdata  = m_axi.rdata;
          s1_axi.rresp  = m_axi.rresp;
          s1_axi.rlast  = m_axi.rlast;
        end else begin
          s0_axi.rvalid = m_axi.rvalid;
          s0_axi.rdata  = m_axi.rdata;
          s0_axi.rresp  = m_axi.rresp;
          s0_axi.rlast  = m_axi.rlast;
        end
        if (m_axi.rvalid && g_rready && m_axi.rlast) begin
          r_last_d  = r_gnt_q;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

endmodule
